bf_loop_unit: RTL and testbench
===============================

Name: bf_loop_unit

Overview:
- Resolves Brainfuck loop control flow for the core, and sits between instruction fetch/decode and the IP register block.
- Consumes the fetched instruction, its address and the current-cell-zero flag.
- Produces the update_ip / jmp / jmp_target controls that the IP register block samples.
- Keeps a hardware return-address stack for '[' and a nesting-depth counter for forward skips over zero-cell loops.

Parameters:
- IW, 16, instruction address width; matches the IP register width.
- STACK_DEPTH, 16, number of loop addresses held; power of two, >= 2.
- SKIP_W, 8, width of the skip nesting counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- instr_valid  in  1  instr/ip hold a fetched instruction this cycle
- instr  in  8  ASCII opcode; '[' = 8'h5B, ']' = 8'h5D; any non-BF byte is a NOP
- ip  in  IW  address of instr
- cell_zero  in  1  data cell at the current pointer equals 0
- exec_done  in  1  datapath finished the current non-loop op (+ - < > . ,)
- update_ip  out  1  advance or jump IP this cycle
- jmp  out  1  with update_ip: load jmp_target instead of ip+1
- jmp_target  out  IW  jump destination
- skipping  out  1  FSM is in SKIP
- loop_depth  out  $clog2(STACK_DEPTH)+1  current stack occupancy
- err  out  1  sticky fault; core halted

Behaviour:
- States: RUN, SKIP, HALT. Reset values: state=RUN, sp=0, skip_cnt=0, err=0.
- update_ip, jmp and jmp_target are combinational from state and inputs, so all three are 0 whenever instr_valid=0 or after reset. Stack, sp, skip_cnt and state are registered.
- RUN, '[' with cell_zero=0:
  - If sp < STACK_DEPTH: push ip, update_ip=1, jmp=0.
  - Else: err<=1, go to HALT, update_ip=0.
- RUN, '[' with cell_zero=1: skip_cnt<=1, go to SKIP, update_ip=1, jmp=0. No push.
- RUN, ']' with cell_zero=0:
  - If sp > 0: update_ip=1, jmp=1, jmp_target=top+1 (mod 2^IW); stack unchanged.
  - If sp = 0: err<=1, go to HALT.
- RUN, ']' with cell_zero=1:
  - If sp > 0: pop, update_ip=1, jmp=0.
  - If sp = 0: err<=1, go to HALT.
- RUN, other BF op: update_ip = exec_done; jmp=0.
- RUN, non-BF byte: update_ip=1 immediately.
- SKIP (cell_zero and exec_done ignored), every valid instr gives update_ip=1, jmp=0:
  - '[': skip_cnt+1. If the counter would wrap: err, go to HALT, no update.
  - ']' with skip_cnt=1: go to RUN, skip_cnt<=0.
  - ']' with skip_cnt>1: skip_cnt-1.
- HALT: all controls 0; only rst_n leaves. loop_depth holds its value for debug.
- Push and jmp never occur in the same cycle; pop and jmp are mutually exclusive by construction.
- Single-cycle resolution; fetch must present the next instruction only after the IP update is visible.
- Reset mid-skip or with a non-empty stack: returns to RUN, sp=0, skip_cnt=0, err=0.
- skipping = (state==SKIP); loop_depth = sp.

Decomposition:
- Shared package bf_pkg:
  - opcode constants OP_LBR=8'h5B, OP_RBR=8'h5D, OP_INC, OP_DEC, OP_LEFT, OP_RIGHT, OP_OUT, OP_IN
  - state enum {RUN, SKIP, HALT}
  - helper function is_bf_op
- Sub-module bf_addr_stack (IW, STACK_DEPTH):
  - Registered LIFO with push, pop, top, count, full, empty.
  - Push when full and pop when empty are ignored; the parent guards both.

Test Plan:
- Reset, then '[' at ip=16'h0010 with cell_zero=0 -> update_ip=1, jmp=0; next cycle loop_depth=1. Then ']' at 16'h0014 with cell_zero=0 -> jmp=1, jmp_target=16'h0011, depth stays 1. Then ']' with cell_zero=1 -> jmp=0, depth=0.
- '[' with cell_zero=1, then stream "[", "+", "]", "]" -> skipping=1 throughout with update_ip=1 each valid cycle. skip_cnt goes 1,2,2,1; skipping falls after the second ']'; no push occurs.
- Push 16 nested '[' with cell_zero=0 (STACK_DEPTH=16), then a 17th '[' -> err=1, update_ip=0; state stays HALT regardless of further inputs until rst_n=0.
- ']' at ip=0 with an empty stack and cell_zero=0 -> err=1, jmp=0.
- '+' with exec_done=0 for 3 cycles, then exec_done=1 -> update_ip low for 3 cycles, high on the 4th. A comment byte 8'h41 -> update_ip=1 immediately.
- In SKIP with skip_cnt=3, assert rst_n=0 for one cycle -> next cycle skipping=0, loop_depth=0, err=0. Then '[' with cell_zero=0 pushes normally.
- Push ip=16'hFFFF, then ']' with cell_zero=0 -> jmp_target=16'h0000 (wrap).

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck loop-control slice: opcodes, FSM state
// encoding and the opcode classifier used by the loop unit.
package bf_pkg;

    localparam logic [7:0] OP_LBR   = 8'h5B;  // '['
    localparam logic [7:0] OP_RBR   = 8'h5D;  // ']'
    localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
    localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
    localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN    = 8'h2C;  // ','

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKIP = 2'd1,
        HALT = 2'd2
    } state_t;

    function automatic logic is_bf_op(input logic [7:0] op);
        return op inside {OP_LBR, OP_RBR, OP_INC, OP_DEC,
                          OP_LEFT, OP_RIGHT, OP_OUT, OP_IN};
    endfunction

endpackage

// File: rtl/bf_addr_stack.sv
// Registered LIFO of loop-start addresses. Push when full and pop when empty
// are dropped here; the parent is expected to guard both.
module bf_addr_stack
    import bf_pkg::*;
#(
    parameter int IW          = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [IW-1:0]                  push_data,
    output logic [IW-1:0]                  top,
    output logic [$clog2(STACK_DEPTH):0]   count,
    output logic                           full,
    output logic                           empty
);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [IW-1:0] mem [STACK_DEPTH];
    logic [AW:0]   sp;
    logic [AW:0]   sp_m1;

    assign sp_m1 = sp - (AW+1)'(1);
    assign full  = (sp == (AW+1)'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign count = sp;
    assign top   = mem[sp_m1[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // NOTE: the storage array has no reset; entries above sp are never read
    // as valid, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bf_loop_unit.sv
// Brainfuck loop control: resolves '[' / ']' into IP advance/jump controls,
// tracking loop starts on a return stack and nesting depth while skipping.
module bf_loop_unit
    import bf_pkg::*;
#(
    parameter int IW          = 16,
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           instr_valid,
    input  logic [7:0]                     instr,
    input  logic [IW-1:0]                  ip,
    input  logic                           cell_zero,
    input  logic                           exec_done,
    output logic                           update_ip,
    output logic                           jmp,
    output logic [IW-1:0]                  jmp_target,
    output logic                           skipping,
    output logic [$clog2(STACK_DEPTH):0]   loop_depth,
    output logic                           err
);
    state_t              state;
    logic [SKIP_W-1:0]   skip_cnt;

    logic                push, pop;
    logic                to_halt, to_skip, to_run, cnt_inc, cnt_dec;
    logic [IW-1:0]       stk_top;
    logic                stk_full, stk_empty;
    logic                is_lbr, is_rbr;

    assign is_lbr = (instr == OP_LBR);
    assign is_rbr = (instr == OP_RBR);

    bf_addr_stack #(
        .IW          (IW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (ip),
        .top       (stk_top),
        .count     (loop_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // NOTE: every output of this block is defaulted first so no path through
    // the case statement leaves a signal unassigned (which would infer a latch).
    always_comb begin
        update_ip  = 1'b0;
        jmp        = 1'b0;
        jmp_target = '0;
        push       = 1'b0;
        pop        = 1'b0;
        to_halt    = 1'b0;
        to_skip    = 1'b0;
        to_run     = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;

        if (instr_valid) begin
            unique case (state)
                RUN: begin
                    if (is_lbr) begin
                        if (cell_zero) begin
                            to_skip   = 1'b1;
                            update_ip = 1'b1;
                        end else if (!stk_full) begin
                            push      = 1'b1;
                            update_ip = 1'b1;
                        end else begin
                            to_halt   = 1'b1;
                        end
                    end else if (is_rbr) begin
                        if (stk_empty) begin
                            to_halt = 1'b1;
                        end else if (cell_zero) begin
                            pop       = 1'b1;
                            update_ip = 1'b1;
                        end else begin
                            update_ip  = 1'b1;
                            jmp        = 1'b1;
                            jmp_target = stk_top + IW'(1);
                        end
                    end else if (is_bf_op(instr)) begin
                        update_ip = exec_done;
                    end else begin
                        update_ip = 1'b1;
                    end
                end
                SKIP: begin
                    if (is_lbr) begin
                        if (skip_cnt == '1) begin
                            to_halt   = 1'b1;
                        end else begin
                            cnt_inc   = 1'b1;
                            update_ip = 1'b1;
                        end
                    end else if (is_rbr) begin
                        update_ip = 1'b1;
                        if (skip_cnt == SKIP_W'(1)) to_run  = 1'b1;
                        else                        cnt_dec = 1'b1;
                    end else begin
                        update_ip = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            skip_cnt <= '0;
            err      <= 1'b0;
        end else if (to_halt) begin
            state <= HALT;
            err   <= 1'b1;
        end else if (to_skip) begin
            state    <= SKIP;
            skip_cnt <= SKIP_W'(1);
        end else if (to_run) begin
            state    <= RUN;
            skip_cnt <= '0;
        end else if (cnt_inc) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
        end else if (cnt_dec) begin
            skip_cnt <= skip_cnt - SKIP_W'(1);
        end
    end

    assign skipping = (state == SKIP);

endmodule

// File: tb/tb_bf_loop_unit.sv
// Directed bench for bf_loop_unit: a vector table for the main flows plus
// hand-written sequences for stack overflow and skip-counter wrap.
module tb_bf_loop_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [7:0]  instr;
    logic [15:0] ip;
    logic        cell_zero;
    logic        exec_done;
    logic        update_ip;
    logic        jmp;
    logic [15:0] jmp_target;
    logic        skipping;
    logic [4:0]  loop_depth;
    logic        err;

    int tests_run;
    int tests_failed;

    bf_loop_unit #(
        .IW          (16),
        .STACK_DEPTH (16),
        .SKIP_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .ip          (ip),
        .cell_zero   (cell_zero),
        .exec_done   (exec_done),
        .update_ip   (update_ip),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .skipping    (skipping),
        .loop_depth  (loop_depth),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected skipping/depth/err describe the registered state before the
    // clock edge that consumes the row's inputs.
    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [7:0]  instr;
        logic [15:0] ip;
        logic        cz;
        logic        ed;
        logic        upd;
        logic        jmp;
        logic [15:0] tgt;
        logic        skp;
        logic [4:0]  dep;
        logic        err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] in,
                                input logic [15:0] a, input logic cz, input logic ed,
                                input logic u, input logic j, input logic [15:0] t,
                                input logic s, input logic [4:0] d, input logic e);
        vec_t x;
        x.rst_n = r; x.valid = v; x.instr = in; x.ip = a; x.cz = cz; x.ed = ed;
        x.upd = u; x.jmp = j; x.tgt = t; x.skp = s; x.dep = d; x.err = e;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] in,
                         input logic [15:0] a, input logic cz, input logic ed);
        @(negedge clk);
        rst_n = r; instr_valid = v; instr = in; ip = a; cell_zero = cz; exec_done = ed;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h00; ip = '0;
        cell_zero = 1'b0; exec_done = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0);

        //        rst  v  instr  ip        cz ed  upd jmp tgt       skp dep err
        // reset state
        vq.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        // push / loop-back / pop
        vq.push_back(mk(1, 1, 8'h5B, 16'h0010, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h5D, 16'h0014, 0, 0, 1, 1, 16'h0011, 0, 1, 0));
        vq.push_back(mk(1, 1, 8'h5D, 16'h0014, 1, 0, 1, 0, 16'h0000, 0, 1, 0));
        vq.push_back(mk(1, 0, 8'h5D, 16'h0015, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        // forward skip over "[ [ + ] ]"
        vq.push_back(mk(1, 1, 8'h5B, 16'h0020, 1, 0, 1, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h5B, 16'h0021, 0, 0, 1, 0, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 1, 8'h2B, 16'h0022, 0, 0, 1, 0, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 1, 8'h5D, 16'h0023, 0, 0, 1, 0, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 1, 8'h5D, 16'h0024, 0, 0, 1, 0, 16'h0000, 1, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 16'h0025, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        // '+' waits on exec_done; comment byte advances at once
        vq.push_back(mk(1, 1, 8'h2B, 16'h0030, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h2B, 16'h0030, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h2B, 16'h0030, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h2B, 16'h0030, 0, 1, 1, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h41, 16'h0031, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
        // jump target wraps from 16'hFFFF
        vq.push_back(mk(1, 1, 8'h5B, 16'hFFFF, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h5D, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 1, 0));
        vq.push_back(mk(1, 1, 8'h5D, 16'h0001, 1, 0, 1, 0, 16'h0000, 0, 1, 0));
        // ']' with empty stack halts; HALT ignores input
        vq.push_back(mk(1, 1, 8'h5D, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h5B, 16'h0002, 0, 0, 0, 0, 16'h0000, 0, 0, 1));
        vq.push_back(mk(1, 1, 8'h41, 16'h0003, 0, 1, 0, 0, 16'h0000, 0, 0, 1));
        vq.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        // reset mid-skip (skip_cnt=3) with one entry on the stack
        vq.push_back(mk(1, 1, 8'h5B, 16'h0030, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h5B, 16'h0031, 1, 0, 1, 0, 16'h0000, 0, 1, 0));
        vq.push_back(mk(1, 1, 8'h5B, 16'h0032, 0, 0, 1, 0, 16'h0000, 1, 1, 0));
        vq.push_back(mk(1, 1, 8'h5B, 16'h0033, 0, 0, 1, 0, 16'h0000, 1, 1, 0));
        vq.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0));
        vq.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 1, 8'h5B, 16'h0040, 0, 0, 1, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0));

        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].valid, vq[i].instr, vq[i].ip, vq[i].cz, vq[i].ed);
            check($sformatf("v%0d.update_ip", i),  32'(update_ip),  32'(vq[i].upd));
            check($sformatf("v%0d.jmp", i),        32'(jmp),        32'(vq[i].jmp));
            check($sformatf("v%0d.jmp_target", i), 32'(jmp_target), 32'(vq[i].tgt));
            check($sformatf("v%0d.skipping", i),   32'(skipping),   32'(vq[i].skp));
            check($sformatf("v%0d.loop_depth", i), 32'(loop_depth), 32'(vq[i].dep));
            check($sformatf("v%0d.err", i),        32'(err),        32'(vq[i].err));
        end

        // Stack overflow: 16 pushes succeed, the 17th halts.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 8'h5B, 16'(i), 1'b0, 1'b0);
            check($sformatf("ovf.push%0d.update_ip", i), 32'(update_ip), 32'd1);
            check($sformatf("ovf.push%0d.depth", i),     32'(loop_depth), 32'(i));
        end
        drive(1'b1, 1'b1, 8'h5B, 16'h0010, 1'b0, 1'b0);
        check("ovf.17th.update_ip", 32'(update_ip), 32'd0);
        check("ovf.17th.depth",     32'(loop_depth), 32'd16);
        drive(1'b1, 1'b1, 8'h5D, 16'h0011, 1'b0, 1'b0);
        check("ovf.halt.err",       32'(err),        32'd1);
        check("ovf.halt.update_ip", 32'(update_ip),  32'd0);
        check("ovf.halt.jmp",       32'(jmp),        32'd0);
        check("ovf.halt.depth",     32'(loop_depth), 32'd16);
        drive(1'b1, 1'b1, 8'h2B, 16'h0012, 1'b0, 1'b1);
        check("ovf.halt2.update_ip", 32'(update_ip), 32'd0);
        check("ovf.halt2.err",       32'(err),       32'd1);
        do_reset();
        check("ovf.reset.err",   32'(err),        32'd0);
        check("ovf.reset.depth", 32'(loop_depth), 32'd0);

        // Skip counter wrap: enter SKIP (cnt=1), 254 more '[' reach 255, next halts.
        drive(1'b1, 1'b1, 8'h5B, 16'h0100, 1'b1, 1'b0);
        check("wrap.enter.update_ip", 32'(update_ip), 32'd1);
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, 1'b1, 8'h5B, 16'h0101, 1'b0, 1'b0);
            if (i == 253) check("wrap.last_ok.update_ip", 32'(update_ip), 32'd1);
        end
        drive(1'b1, 1'b1, 8'h5B, 16'h0102, 1'b0, 1'b0);
        check("wrap.over.update_ip", 32'(update_ip), 32'd0);
        check("wrap.over.skipping",  32'(skipping),  32'd1);
        drive(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        check("wrap.halt.err",      32'(err),      32'd1);
        check("wrap.halt.skipping", 32'(skipping), 32'd0);
        do_reset();
        check("wrap.reset.err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
